// File: rtl/designs_test_sequencer_if.sv
// Pad-side bundle between the test sequencer and the designs wrapper.
// The master end is the sequencer; the slave end is the wrapper/pads.
interface designs_test_sequencer_if;
    logic       i_test;
    logic [3:0] i_done;
    logic [3:0] i_pass;
    logic [3:0] o_enable;
    logic       o_design_rst;
    logic       o_busy;
    logic [4:0] o_result;

    modport master (
        input  i_test,
        input  i_done,
        input  i_pass,
        output o_enable,
        output o_design_rst,
        output o_busy,
        output o_result
    );

    modport slave (
        output i_test,
        output i_done,
        output i_pass,
        input  o_enable,
        input  o_design_rst,
        input  o_busy,
        input  o_result
    );
endinterface

// File: rtl/designs_test_sequencer.sv
// Runs the four wrapped designs in turn: settle in reset, run to done or
// timeout, record pass flags. All outputs are registered.
module designs_test_sequencer #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    designs_test_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, SETTLE, RUN, RECORD, DONE
    } state_e;

    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic [4:0]       result_q, result_d;
    logic [3:0]       enable_q, enable_d;
    logic             drst_q, drst_d;
    logic             busy_q, busy_d;
    logic             test_s;

    assign test_s = sync_q[1];
    assign sync_d = {sync_q[0], bus.i_test};

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            pass_q   <= 1'b0;
            result_q <= '0;
            enable_q <= '0;
            drst_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
            result_q <= result_d;
            enable_q <= enable_d;
            drst_q   <= drst_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                if (test_s) state_d = SETTLE;
            end
            SETTLE: begin
                if (!test_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == SET_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // done is checked first so it beats a same-cycle timeout
                if (!test_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.i_done[idx_q]) begin
                    state_d = RECORD;
                    pass_d  = bus.i_pass[idx_q];
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = RECORD;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            RECORD: begin
                cnt_d = '0;
                if (!test_s) begin
                    state_d = IDLE;
                end else if (idx_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    state_d = SETTLE;
                    idx_d   = idx_q + 2'd1;
                end
            end
            DONE: begin
                cnt_d = '0;
                if (!test_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        enable_d = '0;
        drst_d   = 1'b0;
        busy_d   = 1'b0;
        result_d = result_q;
        if (state_q == RECORD) result_d[idx_q] = pass_q;
        unique case (state_d)
            SETTLE: begin
                enable_d = 4'b0001 << idx_d;
                drst_d   = 1'b1;
                busy_d   = 1'b1;
            end
            RUN, RECORD: begin
                enable_d = 4'b0001 << idx_d;
                busy_d   = 1'b1;
            end
            DONE:    result_d[4] = 1'b1;
            default: result_d = '0;
        endcase
    end

    assign bus.o_enable     = enable_q;
    assign bus.o_design_rst = drst_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_result     = result_q;

endmodule

// File: tb/tb_designs_test_sequencer.sv
// Randomised bench for designs_test_sequencer against a schedule model
// built from per-design done latency and pass values.
module tb_designs_test_sequencer;

    localparam int S = 4;
    localparam int T = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    designs_test_sequencer_if bus ();

    designs_test_sequencer #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T),
        .CNT_W         (16)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // model: design d asserts done in RUN cycle m_l[d] (never if >= T)
    int m_l[4];
    bit m_p[4];
    int m_run[4];
    bit m_pass[4];
    int m_base[5];

    task automatic set_plan(input int l0, input int l1, input int l2,
                            input int l3, input bit [3:0] p);
        m_l[0] = l0; m_l[1] = l1; m_l[2] = l2; m_l[3] = l3;
        m_base[0] = 0;
        for (int d = 0; d < 4; d++) begin
            m_p[d]    = p[d];
            m_run[d]  = (m_l[d] < T) ? m_l[d] + 1 : T;
            m_pass[d] = (m_l[d] < T) ? p[d] : 1'b0;
            m_base[d+1] = m_base[d] + S + m_run[d] + 1;
        end
    endtask

    // st: 0 idle, 1 settle, 2 run, 3 record, 4 done
    task automatic phase(input int e, input int drop, output int st,
                         output int d, output int k);
        int r, o;
        st = 0; d = 0; k = 0;
        r = e - 3;
        if (drop >= 0 && e >= drop + 3) return;
        if (r < 0) return;
        if (r >= m_base[4]) begin
            st = 4;
            return;
        end
        for (int j = 0; j < 4; j++)
            if (r >= m_base[j] && r < m_base[j+1]) d = j;
        o = r - m_base[d];
        if (o < S) st = 1;
        else if (o < S + m_run[d]) begin
            st = 2;
            k  = o - S;
        end else st = 3;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " en"},   32'(bus.o_enable), 0);
        chk({tag, " drst"}, 32'(bus.o_design_rst), 0);
        chk({tag, " busy"}, 32'(bus.o_busy), 0);
        chk({tag, " res"},  32'(bus.o_result), 0);
    endtask

    // edge 1 is the first clock edge after i_test is seen high
    task automatic run_seq(input string nm, input int drop_rel,
                           input bit pulse, input bit noise_hi,
                           input int rst_at);
        int drop, st, d, k;
        logic [3:0] een, dn, ps;
        logic [4:0] eres;
        drop = (drop_rel >= 0) ? drop_rel : 3 + m_base[4] + 2;
        for (int e = 1; e <= drop + 4; e++) begin
            @(posedge clk);
            #1;
            phase(e, drop, st, d, k);
            een  = (st >= 1 && st <= 3) ? 4'(1 << d) : 4'd0;
            eres = '0;
            if (st >= 1 && st <= 3)
                for (int j = 0; j < d; j++) eres[j] = m_pass[j];
            if (st == 4) begin
                for (int j = 0; j < 4; j++) eres[j] = m_pass[j];
                eres[4] = 1'b1;
            end
            chk($sformatf("%s en e%0d", nm, e), 32'(bus.o_enable), 32'(een));
            chk($sformatf("%s drst e%0d", nm, e), 32'(bus.o_design_rst),
                32'(st == 1));
            chk($sformatf("%s busy e%0d", nm, e), 32'(bus.o_busy),
                32'(st >= 1 && st <= 3));
            chk($sformatf("%s res e%0d", nm, e), 32'(bus.o_result), 32'(eres));
            dn = noise_hi ? 4'hF : 4'($urandom);
            ps = 4'($urandom);
            if (st == 2) begin
                dn[d] = pulse ? (k == m_l[d]) : (k >= m_l[d]);
                ps[d] = m_p[d];
            end
            bus.i_done = dn;
            bus.i_pass = ps;
            if (e == drop) bus.i_test = 1'b0;
            if (e == rst_at) begin
                #2 rst = 1'b1;
                #1 check_idle($sformatf("%s async rst", nm));
                #2 rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_test  = 1'b0;
        bus.i_done  = '0;
        bus.i_pass  = '0;
        repeat (2) @(posedge clk);
        #1 check_idle("reset");
        #2 rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 check_idle("idle");
        end

        set_plan(9, 9, 9, 9, 4'b1111);
        bus.i_test = 1'b1;
        run_seq("allpass", -1, 1'b0, 1'b0, -1);

        set_plan(9, 9, 9, 9, 4'b1011);
        bus.i_test = 1'b1;
        run_seq("d2fail", -1, 1'b1, 1'b0, -1);

        set_plan(9, 5000, 9, 9, 4'b1111);
        bus.i_test = 1'b1;
        run_seq("timeout", -1, 1'b0, 1'b0, -1);

        set_plan(3, T - 1, 7, 2, 4'b1111);
        bus.i_test = 1'b1;
        run_seq("edge999", -1, 1'b1, 1'b0, -1);

        set_plan(9, 9, 9, 9, 4'b1111);
        bus.i_test = 1'b1;
        run_seq("abort", 3 + m_base[2] + S + 3, 1'b0, 1'b0, -1);
        bus.i_test = 1'b1;
        run_seq("restart", -1, 1'b0, 1'b0, -1);

        set_plan(6, 6, 6, 6, 4'b1111);
        bus.i_test = 1'b1;
        run_seq("prerst", -1, 1'b0, 1'b1, 3 + m_base[1] + S + 3);
        run_seq("postrst", -1, 1'b0, 1'b1, -1);

        for (int i = 0; i < 6; i++) begin
            int l[4];
            for (int j = 0; j < 4; j++)
                l[j] = ($urandom_range(0, 7) == 0) ? 1500
                                                   : int'($urandom_range(0, 25));
            set_plan(l[0], l[1], l[2], l[3], 4'($urandom));
            bus.i_test = 1'b1;
            run_seq($sformatf("rnd%0d", i), -1, 1'($urandom), 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/designs_test_sequencer.md
# designs_test_sequencer

Sequencer that runs the four designs inside the designs wrapper one at a time: it selects a design, holds it in reset for a settle window, then lets it run until it reports done or a timeout expires. It records a per-design pass flag and drives the 5-bit `o_result` pad bus. It sits between the pad-level `i_test`/`i_clock` inputs and the per-design enable/reset/status nets of the wrapper. `o_result == 5'b11111` means all four designs finished and passed.

## Interface
- `SETTLE_CYCLES`, 4: cycles the selected design is held in `o_design_rst` before running; legal 1..255.
- `TIMEOUT_CYCLES`, 1000: maximum RUN cycles per design before it is failed; legal 2..65535.
- `CNT_W`, 16: width of the shared cycle counter; must hold `TIMEOUT_CYCLES-1`.
- `i_clock`  in  1  single clock for the whole block (pad `mprj_io[13]`).
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_test`  in  1  run request from pad `mprj_io[7]`; asynchronous to `i_clock`, level-sensitive.
- `i_done`  in  4  per-design done strobe/level; only bit `idx` is observed.
- `i_pass`  in  4  per-design pass status; sampled with `i_done[idx]`.
- `o_enable`  out  4  one-hot design select; all zero when idle.
- `o_design_rst`  out  1  active-high reset to the selected design.
- `o_busy`  out  1  high in SETTLE/RUN/RECORD.
- `o_result`  out  5  `[4]` = sequence complete, `[3:0]` = pass flag per design (pad `mprj_io[12:8]`).

## Operation
- `i_test` goes through a 2-flop synchronizer; `test_s` below denotes the synchronized level.
- State `idx` (2 bits) selects the current design. `cnt` (CNT_W bits) is shared by SETTLE and RUN and is cleared on every state entry.
- IDLE: `o_enable=0`, `o_design_rst=0`, `o_result=0`, `idx=0`. Moves to SETTLE when `test_s=1`.
- SETTLE: `o_enable=1<<idx`, `o_design_rst=1`. Leaves for RUN when `cnt==SETTLE_CYCLES-1`.
- RUN: `o_enable=1<<idx`, `o_design_rst=0`.
  - If `i_done[idx]=1`, latch `pass_q=i_pass[idx]` and go to RECORD.
  - Else if `cnt==TIMEOUT_CYCLES-1`, latch `pass_q=0` and go to RECORD.
  - Done and timeout in the same cycle: done wins and pass is sampled.
  - `i_done`/`i_pass` bits for non-selected designs are ignored.
- RECORD: `o_result[idx]<=pass_q`, `o_enable` holds. If `idx==3`, go to DONE. Otherwise `idx<=idx+1` and go to SETTLE.
- DONE: `o_result[4]=1`, `o_result[3:0]` holds, `o_enable=0`, `o_design_rst=0`. Stays until `test_s=0`, then goes to IDLE, which clears `o_result`.
- Abort: `test_s=0` in SETTLE/RUN/RECORD goes to IDLE next cycle. All outputs return to IDLE values and partial results are discarded.
- Reset (any time, asynchronous): state=IDLE, synchronizer flops=0, `idx=0`, `cnt=0`, `pass_q=0`, `o_enable=0`, `o_design_rst=0`, `o_busy=0`, `o_result=5'b00000`.
- Outputs are registered; no combinational path from inputs to outputs.

## Timing
- Start latency: `i_test` rising is seen as `test_s` 2 edges later. SETTLE is entered on the following edge.
- SETTLE lasts exactly `SETTLE_CYCLES` cycles.
- RUN observes `i_done[idx]` starting in its first cycle. `i_done` high in RUN cycle k (k from 0) gives RECORD in cycle k+1 and `o_result[idx]` visible in cycle k+2.
- A timeout fails a design after exactly `TIMEOUT_CYCLES` RUN cycles.
- Per-design period: `SETTLE_CYCLES + run_cycles + 1` (RECORD).
- `o_result[4]` rises one cycle after RECORD of design 3. Bits `[3:0]` are already stable at that point, so a monitor triggering on `o_result[4]` reads the final value.
- `i_done` may be a level or a one-cycle pulse. A pulse during SETTLE is not retained.

## Test plan
- Reset, then `i_test=1`, all designs assert done with pass=1 after 10 RUN cycles: `o_enable` steps 0001→0010→0100→1000, `o_design_rst` high for 4 cycles each; ends with `o_result=5'b11111`, `o_busy=0`.
- Design 2 returns pass=0: final `o_result=5'b11011`.
- Design 1 never asserts done: it stays in RUN for exactly 1000 cycles, then the sequence continues; final `o_result=5'b11101`.
- `i_done[idx]` rises exactly in RUN cycle 999 with `i_pass=1`: the design is recorded as pass (done beats timeout).
- `i_test` dropped during design 2 RUN: IDLE within 3 cycles, `o_enable=0`, `o_result=0`. Re-raising `i_test` restarts from design 0.
- `i_reset` pulsed mid-RUN asynchronously: all outputs go to 0 immediately without waiting for a clock edge. With `i_test` held high, a fresh sequence starts after the synchronizer latency; `i_done` bits of non-selected designs held high throughout have no effect.
